// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: shifts a WIDTH-bit word out LSB first with
// first/last framing strobes and an optional idle gap between words.
module serial_word_tx #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dataout,
  output logic             dout_valid,
  output logic             first,
  output logic             last,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
  localparam logic [3:0] GapInit = 4'(GAP);
  localparam bit NoGap = (GAP == 0);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic              dataout_q, dataout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              last_bit;

  assign last_bit = (bit_cnt_q == LastBit);

  // With no gap, the last-bit cycle also accepts the next word for bubble-free streaming.
  assign din_ready = (state_q == StIdle) || ((state_q == StShift) && last_bit && NoGap);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      dataout_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      dataout_q    <= dataout_d;
      dout_valid_q <= dout_valid_d;
      first_q      <= first_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (din_valid) begin
          state_d   = StShift;
          shreg_d   = din;
          bit_cnt_d = '0;
        end
      end
      StShift: begin
        if (last_bit) begin
          if (!NoGap) begin
            state_d   = StGap;
            gap_cnt_d = GapInit;
          end else if (din_valid) begin
            shreg_d   = din;
            bit_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q <= 4'd1) begin
          state_d   = StIdle;
          gap_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    dout_valid_d = (state_d == StShift);
    dataout_d    = dout_valid_d & shreg_d[0];
    first_d      = dout_valid_d && (bit_cnt_d == '0);
    last_d       = dout_valid_d && (bit_cnt_d == LastBit);
    busy_d       = (state_d != StIdle);
  end

  assign dataout    = dataout_q;
  assign dout_valid = dout_valid_q;
  assign first      = first_q;
  assign last       = last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: two instances (GAP=0 and GAP=2) share stimulus and are
// checked every cycle against a word/bits-left/gap-left reference model.
module tb_serial_word_tx;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic [1:0] rdy, dat, dv, fst, lst, bsy;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance
  logic [3:0] m_word [2];
  int         m_left [2];
  int         m_gap  [2];

  // Serial consumer: reassembles words from instance 0 and sums them mod 16
  logic [3:0] acc_word;
  int         acc_pos;
  logic [3:0] acc_sum;
  int         acc_words;

  always #5 clk = ~clk;

  serial_word_tx #(.WIDTH(W), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy[0]),
    .dataout(dat[0]), .dout_valid(dv[0]), .first(fst[0]), .last(lst[0]), .busy(bsy[0])
  );

  serial_word_tx #(.WIDTH(W), .GAP(2)) u_dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy[1]),
    .dataout(dat[1]), .dout_valid(dv[1]), .first(fst[1]), .last(lst[1]), .busy(bsy[1])
  );

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       rdy;
    logic       dv;
    logic       dat;
    logic       f;
    logic       l;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(logic v, logic [3:0] d, logic r, logic o_dv, logic o_dat,
                              logic o_f, logic o_l);
    vec_t t;
    t.v = v; t.d = d; t.rdy = r; t.dv = o_dv; t.dat = o_dat; t.f = o_f; t.l = o_l;
    return t;
  endfunction

  function automatic int gap_of(int k);
    return (k == 1) ? 2 : 0;
  endfunction

  function automatic logic m_rdy(int k);
    return (m_left[k] == 0 && m_gap[k] == 0) || (gap_of(k) == 0 && m_left[k] == 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_word[k] = '0; m_left[k] = 0; m_gap[k] = 0;
    end
  endtask

  // One clock: drive inputs, check ready, advance, update model, check outputs.
  task automatic cyc(input logic r, input logic v, input logic [3:0] d);
    logic acc [2];
    rst = r; din_valid = v; din = d;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("din_ready%0d", k), 32'(rdy[k]), 32'(m_rdy(k)));
      acc[k] = m_rdy(k) && v && !r;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_left[k] = 0; m_gap[k] = 0;
      end else begin
        if (m_left[k] > 0) begin
          m_left[k]--;
          if (m_left[k] == 0 && gap_of(k) > 0) m_gap[k] = gap_of(k);
        end else if (m_gap[k] > 0) begin
          m_gap[k]--;
        end
        if (acc[k]) begin
          m_word[k] = d; m_left[k] = W;
        end
      end
      chk($sformatf("dout_valid%0d", k), 32'(dv[k]), 32'(m_left[k] > 0));
      chk($sformatf("dataout%0d", k), 32'(dat[k]),
          (m_left[k] > 0) ? 32'((m_word[k] >> (W - m_left[k])) & 4'd1) : 32'd0);
      chk($sformatf("first%0d", k), 32'(fst[k]), 32'(m_left[k] == W));
      chk($sformatf("last%0d", k), 32'(lst[k]), 32'(m_left[k] == 1));
      chk($sformatf("busy%0d", k), 32'(bsy[k]), 32'(m_left[k] > 0 || m_gap[k] > 0));
    end
    if (dv[0] === 1'b1) begin
      if (fst[0] === 1'b1) begin acc_word = '0; acc_pos = 0; end
      acc_word[acc_pos[1:0]] = dat[0];
      acc_pos++;
      if (lst[0] === 1'b1) begin acc_sum = acc_sum + acc_word; acc_words++; end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    logic [10:0] e_dv, e_dat, e_rdy;
    logic [3:0]  bits;
    logic [3:0]  words [3];
    logic        was_rdy;
    int          tries;

    acc_word = '0; acc_pos = 0; acc_sum = '0; acc_words = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_dv%0d", k), 32'(dv[k]), 32'd0);
      chk($sformatf("reset_dat%0d", k), 32'(dat[k]), 32'd0);
      chk($sformatf("reset_first%0d", k), 32'(fst[k]), 32'd0);
      chk($sformatf("reset_last%0d", k), 32'(lst[k]), 32'd0);
      chk($sformatf("reset_busy%0d", k), 32'(bsy[k]), 32'd0);
      chk($sformatf("reset_rdy%0d", k), 32'(rdy[k]), 32'd1);
    end
    idle(5);

    // Single word 1011, then 3 and C streamed back to back (GAP=0 instance)
    tbl[0]  = mk(1, 4'hB, 1, 1, 1, 1, 0);
    tbl[1]  = mk(0, 4'h0, 0, 1, 1, 0, 0);
    tbl[2]  = mk(0, 4'h0, 0, 1, 0, 0, 0);
    tbl[3]  = mk(0, 4'h0, 0, 1, 1, 0, 1);
    tbl[4]  = mk(0, 4'h0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 4'h0, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 4'h3, 1, 1, 1, 1, 0);
    tbl[7]  = mk(1, 4'hC, 0, 1, 1, 0, 0);
    tbl[8]  = mk(1, 4'hC, 0, 1, 0, 0, 0);
    tbl[9]  = mk(1, 4'hC, 0, 1, 0, 0, 1);
    tbl[10] = mk(1, 4'hC, 1, 1, 0, 1, 0);
    tbl[11] = mk(0, 4'h0, 0, 1, 0, 0, 0);
    tbl[12] = mk(0, 4'h0, 0, 1, 1, 0, 0);
    tbl[13] = mk(0, 4'h0, 0, 1, 1, 0, 1);
    tbl[14] = mk(0, 4'h0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("tbl%0d_rdy", i), 32'(rdy[0]), 32'(tbl[i].rdy));
      cyc(1'b0, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_dv", i), 32'(dv[0]), 32'(tbl[i].dv));
      chk($sformatf("tbl%0d_dat", i), 32'(dat[0]), 32'(tbl[i].dat));
      chk($sformatf("tbl%0d_first", i), 32'(fst[0]), 32'(tbl[i].f));
      chk($sformatf("tbl%0d_last", i), 32'(lst[0]), 32'(tbl[i].l));
    end
    idle(6);

    // GAP=2 instance: 5 then A, two gap cycles and one idle accept cycle between them
    e_dv  = 11'b11110001111;
    e_dat = 11'b10100000101;
    e_rdy = 11'b00010000001;
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("gap_rdy%0d", i), 32'(rdy[1]), 32'(e_rdy[i]));
      cyc(1'b0, (i < 8), (i == 0) ? 4'h5 : 4'hA);
      chk($sformatf("gap_dv%0d", i), 32'(dv[1]), 32'(e_dv[i]));
      chk($sformatf("gap_dat%0d", i), 32'(dat[1]), 32'(e_dat[i]));
    end
    idle(6);

    // Reset aborts a word after its second bit; next word is clean
    cyc(1'b0, 1'b1, 4'hF);
    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0);
    chk("abort_dv", 32'(dv[0]), 32'd0);
    chk("abort_busy", 32'(bsy[0]), 32'd0);
    chk("abort_rdy", 32'(rdy[0]), 32'd1);
    cyc(1'b0, 1'b1, 4'h1);
    bits[0] = dat[0];
    for (int i = 1; i < 4; i++) begin
      cyc(1'b0, 1'b0, 4'h0);
      bits[i] = dat[0];
    end
    chk("after_abort_word", 32'(bits), 32'h1);
    idle(6);

    // Mid-word din changes and valid pulses are ignored
    cyc(1'b0, 1'b1, 4'h6);
    bits[0] = dat[0];
    for (int i = 1; i < 4; i++) begin
      cyc(1'b0, i[0], 4'h9);
      bits[i] = dat[0];
    end
    chk("inflight_word", 32'(bits), 32'h6);
    idle(6);

    // Accept coincident with reset is dropped
    cyc(1'b1, 1'b1, 4'hF);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 4'h0);
      chk($sformatf("drop_dv%0d", i), 32'(dv[0]), 32'd0);
    end

    // Words 3, 5, 7 streamed into the serial accumulator
    acc_sum = '0; acc_words = 0;
    words[0] = 4'h3; words[1] = 4'h5; words[2] = 4'h7;
    for (int w = 0; w < 3; w++) begin
      tries = 0;
      do begin
        was_rdy = rdy[0];
        cyc(1'b0, 1'b1, words[w]);
        tries++;
      end while (!was_rdy && tries < 20);
      if (!was_rdy) chk("accept_timeout", 32'(was_rdy), 32'd1);
    end
    idle(6);
    chk("acc_sum", 32'(acc_sum), 32'hF);
    chk("acc_words", 32'(acc_words), 32'd3);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), 4'($urandom));
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial word transmitter. It produces the LSB-first serial bit stream consumed by the 4-bit serial accumulator datapath.
- It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock.
- It emits first-bit and last-bit framing strobes so downstream serial logic can align word boundaries.
- Optional idle gap cycles can be inserted between words.

Parameters:
- WIDTH, 4: word width in bits, range 2..16.
- GAP, 0: idle cycles forced between the last bit of one word and the first bit of the next, range 0..15.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word this cycle.
- dataout  output  1  serial data, LSB first.
- dout_valid  output  1  dataout carries a valid bit.
- first  output  1  dataout is bit 0 of a word.
- last  output  1  dataout is bit WIDTH-1 of a word.
- busy  output  1  a word is being shifted or a gap is running.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- All outputs are registered except din_ready, which is combinational from state and counter.
- Reset:
  - On a clk edge with rst=1, state goes to IDLE and all registers clear: shift register, bit counter, gap counter.
  - dataout=0, dout_valid=0, first=0, last=0, busy=0.
  - rst overrides everything, including a handshake in the same cycle; that word is dropped.
  - Reset mid-word aborts it; the remaining bits are never sent.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: din_ready=1. When din_valid=1, capture din and move to SHIFT. The next cycle presents bit 0 (latency 1 clk from accept to first bit).
  - SHIFT: dout_valid=1 and dataout=shreg[0]. Shift right each cycle and increment bit_cnt (0..WIDTH-1). first=1 when bit_cnt==0; last=1 when bit_cnt==WIDTH-1. On the last bit:
    - If GAP>0, go to GAP with gap_cnt=GAP.
    - If GAP=0, din_ready=1 in this cycle. When din_valid=1, load the new word and stay in SHIFT with bit_cnt=0, giving back-to-back words with no bubble. Otherwise go to IDLE.
  - GAP: dout_valid=0, dataout=0, din_ready=0. Decrement gap_cnt; when it reaches 1, go to IDLE.
- din_ready=0 in SHIFT except the last-bit cycle with GAP=0, and 0 in GAP.
  - din_valid asserted while din_ready=0 is ignored; no capture and no error.
  - The source must hold din_valid and din until accepted.
- din is sampled only at the accept edge; later changes to din do not affect the word in flight.
- When dout_valid=0: dataout=0, first=0, last=0.
- busy=1 in SHIFT and GAP, 0 in IDLE.
- Bit count: exactly WIDTH dout_valid cycles per accepted word, never more, never fewer, except when aborted by reset.

Test Plan:
1. WIDTH=4, GAP=0. After reset, din=4'b1011 with din_valid pulsed 1 cycle → dataout 1,1,0,1 on cycles 1..4 after accept. first only on cycle 1, last only on cycle 4, dout_valid high for exactly 4 cycles, then IDLE and din_ready=1.
2. WIDTH=4, GAP=0, din_valid held high with words 4'h3 then 4'hC → serial 1,1,0,0,0,0,1,1 with no bubble. The second accept occurs on the last-bit cycle of the first word; last/first are adjacent.
3. WIDTH=4, GAP=2, words 4'h5, 4'hA back-to-back → 1,0,1,0, then 2 cycles with dout_valid=0 and din_ready=0, then 1 cycle IDLE accept, then 0,1,0,1.
4. Assert rst after the 2nd bit of 4'hF → on the next edge dout_valid=0, busy=0, din_ready=1. The remaining bits are never sent, and a new 4'h1 then transmits 1,0,0,0 correctly.
5. While in SHIFT, toggle din and pulse din_valid mid-word → no capture and the in-flight word is unchanged. Also, accept together with rst=1 → nothing transmitted.
6. End-to-end: drive the serial accumulator from dataout with words 3, 5, 7 (GAP=0) → accumulator sum reads 4'hF, mod-16 wrap consistent with 3+5+7=15.
